// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus of the responder: a level read request with a one-cycle
// acknowledge, and a write strobe that is never acknowledged.
interface cpu_bus_responder_if;
    logic [15:0] bus_addr;
    logic        rd_req;
    logic        rd_ack;
    logic [7:0]  rd_data;
    logic        wr_enable;
    logic [7:0]  wr_data;
    logic        wr_overflow;

    modport master (
        output bus_addr, rd_req, wr_enable, wr_data,
        input  rd_ack, rd_data, wr_overflow
    );

    modport slave (
        input  bus_addr, rd_req, wr_enable, wr_data,
        output rd_ack, rd_data, wr_overflow
    );
endinterface

// File: rtl/cpu_bus_responder.sv
// Answers CPU reads from a backing RAM (or the read-only reset-vector overlay)
// and posts CPU writes through a one-entry buffer that drains while idle.
module cpu_bus_responder #(
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [15:0] RESET_VECTOR = 16'h0444
) (
    input  logic                      clk,
    input  logic                      reset_n,
    cpu_bus_responder_if.slave        bus,
    output logic [15:0]               mem_addr,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        ACK
    } state_t;

    localparam logic [15:0] VEC_LO_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_HI_ADDR = 16'hFFFD;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_ack_q, rd_ack_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        ovf_q, ovf_d;

    logic        draining;
    logic        is_vec;
    logic [7:0]  vec_byte;

    // Buffered write leaves for RAM at this edge, freeing the slot for a new one.
    assign draining = (state_q == IDLE) && buf_valid_q;
    assign is_vec   = (bus.bus_addr == VEC_LO_ADDR) || (bus.bus_addr == VEC_HI_ADDR);
    assign vec_byte = bus.bus_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_ack_d    = 1'b0;
        rd_data_d   = rd_data_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (draining) begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = buf_addr_q;
                    mem_wdata_d = buf_data_q;
                    buf_valid_d = 1'b0;
                end else if (bus.rd_req) begin
                    if (is_vec) begin
                        rd_data_d = vec_byte;
                        rd_ack_d  = 1'b1;
                        state_d   = ACK;
                    end else if (!bus.wr_enable) begin
                        // A write arriving this edge is drained first so the
                        // read observes it.
                        mem_rd_d   = 1'b1;
                        mem_addr_d = bus.bus_addr;
                        cnt_d      = 16'(WAIT_STATES);
                        state_d    = MEM_WAIT;
                    end
                end
            end

            MEM_WAIT: begin
                // The first MEM_WAIT edge is the RAM's own read cycle; wait
                // states are counted only after the data is available.
                if (!mem_rd_q) begin
                    if (cnt_q == 16'd0) begin
                        rd_data_d = mem_rdata;
                        rd_ack_d  = 1'b1;
                        state_d   = ACK;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end

            ACK: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.wr_enable) begin
            if (!buf_valid_q || draining) begin
                buf_valid_d = 1'b1;
                buf_addr_d  = bus.bus_addr;
                buf_data_d  = bus.wr_data;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= 8'd0;
            mem_addr_q  <= 16'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= 16'd0;
            buf_data_q  <= 8'd0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.rd_ack      = rd_ack_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_overflow = ovf_q;
    assign mem_addr        = mem_addr_q;
    assign mem_rd          = mem_rd_q;
    assign mem_wr          = mem_wr_q;
    assign mem_wdata       = mem_wdata_q;

    a_one_strobe: assert property (@(posedge clk) !(mem_rd_q && mem_wr_q));

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: default build plus WAIT_STATES=0/7 builds,
// each backed by a behavioural RAM.
module tb_cpu_bus_responder;
    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cpu_bus_responder_if b0 ();
    cpu_bus_responder_if b1 ();
    cpu_bus_responder_if b7 ();

    logic [15:0] mem_addr0, mem_addr1, mem_addr7;
    logic        mem_rd0, mem_rd1, mem_rd7;
    logic        mem_wr0, mem_wr1, mem_wr7;
    logic [7:0]  mem_wdata0, mem_wdata1, mem_wdata7;
    logic [7:0]  mem_rdata0, mem_rdata1, mem_rdata7;
    logic [7:0]  ram0 [int];
    logic [7:0]  ram1 [int];
    logic [7:0]  ram7 [int];

    cpu_bus_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(b0), .mem_addr(mem_addr0), .mem_rd(mem_rd0),
        .mem_wr(mem_wr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0));
    cpu_bus_responder #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1), .mem_addr(mem_addr1), .mem_rd(mem_rd1),
        .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1));
    cpu_bus_responder #(.WAIT_STATES(7)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .bus(b7), .mem_addr(mem_addr7), .mem_rd(mem_rd7),
        .mem_wr(mem_wr7), .mem_wdata(mem_wdata7), .mem_rdata(mem_rdata7));

    // Unwritten RAM locations read as zero.
    always @(posedge clk) begin
        if (mem_wr0) ram0[int'(mem_addr0)] = mem_wdata0;
        if (mem_rd0) mem_rdata0 <= ram0.exists(int'(mem_addr0)) ? ram0[int'(mem_addr0)] : 8'h00;
        if (mem_wr1) ram1[int'(mem_addr1)] = mem_wdata1;
        if (mem_rd1) mem_rdata1 <= ram1.exists(int'(mem_addr1)) ? ram1[int'(mem_addr1)] : 8'h00;
        if (mem_wr7) ram7[int'(mem_addr7)] = mem_wdata7;
        if (mem_rd7) mem_rdata7 <= ram7.exists(int'(mem_addr7)) ? ram7[int'(mem_addr7)] : 8'h00;
    end

    typedef struct {
        int          ack_k;
        int          n_ack;
        logic [7:0]  ack_data;
        int          mrd_k;
        int          n_mrd;
        logic [15:0] mrd_addr;
        int          mwr_k;
        int          n_mwr;
        logic [15:0] mwr_addr;
        logic [7:0]  mwr_data;
        int          n_both;
    } obs_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        b1.rd_req    = 1'b0;
        b1.wr_enable = 1'b0;
        repeat (n) step();
    endtask

    // Steps the default build with the stimulus already on the bus; k=0 is the
    // first edge. rd_req drops once rd_ack is seen (or right away if drop_early).
    task automatic run_obs(input int max_k, input bit drop_early, output obs_t o);
        o = '{ack_k: -1, n_ack: 0, ack_data: 8'h00, mrd_k: -1, n_mrd: 0, mrd_addr: 16'h0,
              mwr_k: -1, n_mwr: 0, mwr_addr: 16'h0, mwr_data: 8'h00, n_both: 0};
        for (int k = 0; k < max_k; k++) begin
            step();
            if (b1.rd_ack) begin
                if (o.n_ack == 0) begin o.ack_k = k; o.ack_data = b1.rd_data; end
                o.n_ack++;
                b1.rd_req = 1'b0;
            end
            if (mem_rd1) begin
                if (o.n_mrd == 0) begin o.mrd_k = k; o.mrd_addr = mem_addr1; end
                o.n_mrd++;
            end
            if (mem_wr1) begin
                if (o.n_mwr == 0) begin o.mwr_k = k; o.mwr_addr = mem_addr1; o.mwr_data = mem_wdata1; end
                o.n_mwr++;
            end
            if (mem_rd1 && mem_wr1) o.n_both++;
            b1.wr_enable = 1'b0;
            if (drop_early) b1.rd_req = 1'b0;
        end
    endtask

    task automatic ws_set(input int sel, input logic rq, input logic [15:0] a,
                          input logic we, input logic [7:0] wd);
        if (sel == 0) begin
            b0.rd_req = rq; b0.bus_addr = a; b0.wr_enable = we; b0.wr_data = wd;
        end else begin
            b7.rd_req = rq; b7.bus_addr = a; b7.wr_enable = we; b7.wr_data = wd;
        end
    endtask

    task automatic ws_get(input int sel, output logic ack, output logic [7:0] d);
        if (sel == 0) begin ack = b0.rd_ack; d = b0.rd_data; end
        else          begin ack = b7.rd_ack; d = b7.rd_data; end
    endtask

    task automatic ws_read(input int sel, input logic [15:0] a, output logic [7:0] rd, output int lat);
        logic ack;
        logic [7:0] d;
        lat = -1;
        rd  = 8'h00;
        ws_set(sel, 1'b1, a, 1'b0, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step();
            ws_get(sel, ack, d);
            if (ack) begin
                lat = k;
                rd  = d;
                break;
            end
        end
        ws_set(sel, 1'b0, a, 1'b0, 8'h00);
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) step();
        total++;
        if ({b1.rd_ack, b1.rd_data, mem_rd1, mem_wr1, mem_addr1, mem_wdata1, b1.wr_overflow} !== 36'h0) begin
            bad++; $display("FAIL reset_ws1: got %h want 0",
                {b1.rd_ack, b1.rd_data, mem_rd1, mem_wr1, mem_addr1, mem_wdata1, b1.wr_overflow});
        end
        total++;
        if ({b0.rd_ack, b0.rd_data, mem_rd0, mem_wr0, mem_addr0, mem_wdata0, b0.wr_overflow} !== 36'h0) begin
            bad++; $display("FAIL reset_ws0: got %h want 0",
                {b0.rd_ack, b0.rd_data, mem_rd0, mem_wr0, mem_addr0, mem_wdata0, b0.wr_overflow});
        end
        total++;
        if ({b7.rd_ack, b7.rd_data, mem_rd7, mem_wr7, mem_addr7, mem_wdata7, b7.wr_overflow} !== 36'h0) begin
            bad++; $display("FAIL reset_ws7: got %h want 0",
                {b7.rd_ack, b7.rd_data, mem_rd7, mem_wr7, mem_addr7, mem_wdata7, b7.wr_overflow});
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        obs_t o;
        b1.bus_addr = 16'h0450; b1.wr_data = 8'hA9; b1.wr_enable = 1'b1;
        step();
        idle(3);
        b1.bus_addr = 16'h0450; b1.rd_req = 1'b1;
        run_obs(8, 1'b0, o);
        total++; if (o.mrd_k !== 0) begin bad++; $display("FAIL basic_mrd_edge: got %0d want 0", o.mrd_k); end
        total++; if (o.n_mrd !== 1) begin bad++; $display("FAIL basic_mrd_count: got %0d want 1", o.n_mrd); end
        total++; if (o.mrd_addr !== 16'h0450) begin bad++; $display("FAIL basic_mrd_addr: got %h want 0450", o.mrd_addr); end
        total++; if (o.ack_k !== 3) begin bad++; $display("FAIL basic_ack_edge: got %0d want 3", o.ack_k); end
        total++; if (o.ack_data !== 8'hA9) begin bad++; $display("FAIL basic_data: got %h want a9", o.ack_data); end
        total++; if (o.n_ack !== 1) begin bad++; $display("FAIL basic_ack_count: got %0d want 1", o.n_ack); end
        idle(2);
    endtask

    task automatic test_vector();
        int ks [2];
        logic [7:0] ds [2];
        int n_ack = 0;
        int n_mrd = 0;
        ks = '{-1, -1};
        ds = '{8'h00, 8'h00};
        b1.bus_addr = 16'hFFFC; b1.rd_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (mem_rd1) n_mrd++;
            if (b1.rd_ack) begin
                if (n_ack < 2) begin ks[n_ack] = k; ds[n_ack] = b1.rd_data; end
                n_ack++;
                if (n_ack == 1) b1.bus_addr = 16'hFFFD;
                else            b1.rd_req = 1'b0;
            end
        end
        total++; if (n_ack !== 2) begin bad++; $display("FAIL vec_ack_count: got %0d want 2", n_ack); end
        total++; if (ks[0] !== 0 || ds[0] !== 8'h44) begin bad++; $display("FAIL vec_lo: got edge %0d data %h want edge 0 data 44", ks[0], ds[0]); end
        total++; if (ks[1] !== 2 || ds[1] !== 8'h04) begin bad++; $display("FAIL vec_hi: got edge %0d data %h want edge 2 data 04", ks[1], ds[1]); end
        total++; if (n_mrd !== 0) begin bad++; $display("FAIL vec_no_mem_rd: got %0d want 0", n_mrd); end
        idle(2);
    endtask

    task automatic test_write_then_read();
        obs_t o;
        b1.bus_addr = 16'h2000; b1.wr_data = 8'h5A; b1.wr_enable = 1'b1; b1.rd_req = 1'b1;
        run_obs(12, 1'b0, o);
        total++; if (o.mwr_k !== 1 || o.n_mwr !== 1) begin bad++; $display("FAIL wtr_mem_wr: got edge %0d count %0d want edge 1 count 1", o.mwr_k, o.n_mwr); end
        total++; if (o.mwr_addr !== 16'h2000 || o.mwr_data !== 8'h5A) begin bad++; $display("FAIL wtr_wr_bus: got %h/%h want 2000/5a", o.mwr_addr, o.mwr_data); end
        total++; if (o.mrd_k !== 2) begin bad++; $display("FAIL wtr_mrd_edge: got %0d want 2", o.mrd_k); end
        total++; if (o.ack_k !== 5 || o.ack_data !== 8'h5A) begin bad++; $display("FAIL wtr_ack: got edge %0d data %h want edge 5 data 5a", o.ack_k, o.ack_data); end
        total++; if (o.n_both !== 0) begin bad++; $display("FAIL wtr_strobe_overlap: got %0d want 0", o.n_both); end
        idle(2);
    endtask

    task automatic test_drop_req();
        obs_t o;
        b1.bus_addr = 16'h0450; b1.rd_req = 1'b1;
        run_obs(8, 1'b1, o);
        total++; if (o.ack_k !== 3 || o.n_ack !== 1) begin bad++; $display("FAIL drop_ack: got edge %0d count %0d want edge 3 count 1", o.ack_k, o.n_ack); end
        total++; if (o.ack_data !== 8'hA9) begin bad++; $display("FAIL drop_data: got %h want a9", o.ack_data); end
        idle(2);
    endtask

    task automatic test_write_vector();
        obs_t o;
        b1.bus_addr = 16'hFFFC; b1.wr_data = 8'h99; b1.wr_enable = 1'b1;
        run_obs(4, 1'b0, o);
        total++; if (o.n_mwr !== 1 || o.mwr_addr !== 16'hFFFC || o.mwr_data !== 8'h99) begin
            bad++; $display("FAIL wvec_mem_wr: got count %0d %h/%h want 1 fffc/99", o.n_mwr, o.mwr_addr, o.mwr_data);
        end
        b1.bus_addr = 16'hFFFC; b1.rd_req = 1'b1;
        run_obs(4, 1'b0, o);
        total++; if (o.ack_k !== 0 || o.ack_data !== 8'h44 || o.n_mrd !== 0) begin
            bad++; $display("FAIL wvec_readback: got edge %0d data %h mem_rd %0d want 0 44 0", o.ack_k, o.ack_data, o.n_mrd);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        obs_t o;
        int ack_k = -1;
        int n_mwr = 0;
        int mwr_k = -1;
        logic [7:0]  ack_d = 8'h00;
        logic [15:0] mwr_a = 16'h0;
        logic [7:0]  mwr_d = 8'h00;
        logic ov1 = 1'bx;
        logic ov2 = 1'bx;
        b1.bus_addr = 16'h0450; b1.rd_req = 1'b1; b1.wr_enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (b1.rd_ack) begin ack_k = k; ack_d = b1.rd_data; b1.rd_req = 1'b0; end
            if (mem_wr1) begin n_mwr++; mwr_k = k; mwr_a = mem_addr1; mwr_d = mem_wdata1; end
            if (k == 1) ov1 = b1.wr_overflow;
            if (k == 2) ov2 = b1.wr_overflow;
            case (k)
                0: begin b1.wr_enable = 1'b1; b1.bus_addr = 16'h3000; b1.wr_data = 8'h11; end
                1: begin b1.wr_enable = 1'b1; b1.bus_addr = 16'h3001; b1.wr_data = 8'h22; end
                2: begin b1.wr_enable = 1'b1; b1.bus_addr = 16'h3002; b1.wr_data = 8'h33; end
                3: b1.wr_enable = 1'b0;
                default: ;
            endcase
        end
        total++; if (ov1 !== 1'b0 || ov2 !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b then %b want 0 then 1", ov1, ov2); end
        total++; if (ack_k !== 3 || ack_d !== 8'hA9) begin bad++; $display("FAIL ovf_read: got edge %0d data %h want edge 3 data a9", ack_k, ack_d); end
        total++; if (n_mwr !== 1 || mwr_k !== 5) begin bad++; $display("FAIL ovf_drain: got count %0d edge %0d want 1 at 5", n_mwr, mwr_k); end
        total++; if (mwr_a !== 16'h3000 || mwr_d !== 8'h11) begin bad++; $display("FAIL ovf_drain_bus: got %h/%h want 3000/11", mwr_a, mwr_d); end
        b1.bus_addr = 16'h3000; b1.rd_req = 1'b1;
        run_obs(8, 1'b0, o);
        total++; if (o.ack_data !== 8'h11) begin bad++; $display("FAIL ovf_kept: got %h want 11", o.ack_data); end
        idle(1);
        b1.bus_addr = 16'h3001; b1.rd_req = 1'b1;
        run_obs(8, 1'b0, o);
        total++; if (o.ack_data !== 8'h00) begin bad++; $display("FAIL ovf_dropped: got %h want 00", o.ack_data); end
        total++; if (b1.wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", b1.wr_overflow); end
        idle(2);
    endtask

    task automatic test_reset_mid();
        obs_t o;
        b1.bus_addr = 16'h0450; b1.rd_req = 1'b1;
        step();
        total++; if (mem_rd1 !== 1'b1) begin bad++; $display("FAIL rmid_started: got %b want 1", mem_rd1); end
        b1.bus_addr = 16'h4000; b1.wr_data = 8'h77; b1.wr_enable = 1'b1;
        step();
        b1.wr_enable = 1'b0; b1.rd_req = 1'b0; reset_n = 1'b0;
        step();
        total++;
        if ({b1.rd_ack, b1.rd_data, mem_rd1, mem_wr1, mem_addr1, mem_wdata1, b1.wr_overflow} !== 36'h0) begin
            bad++; $display("FAIL rmid_zero: got %h want 0",
                {b1.rd_ack, b1.rd_data, mem_rd1, mem_wr1, mem_addr1, mem_wdata1, b1.wr_overflow});
        end
        reset_n = 1'b1; b1.bus_addr = 16'h0450; b1.rd_req = 1'b1;
        run_obs(10, 1'b0, o);
        total++; if (o.mrd_k !== 0) begin bad++; $display("FAIL rmid_first_accept: got %0d want 0", o.mrd_k); end
        total++; if (o.ack_k !== 3 || o.n_ack !== 1 || o.ack_data !== 8'hA9) begin
            bad++; $display("FAIL rmid_read: got edge %0d count %0d data %h want 3 1 a9", o.ack_k, o.n_ack, o.ack_data);
        end
        total++; if (o.n_mwr !== 0) begin bad++; $display("FAIL rmid_no_write: got %0d want 0", o.n_mwr); end
        idle(2);
    endtask

    task automatic test_wait_states();
        logic [7:0] sh [16];
        logic [7:0] rd;
        logic [15:0] a;
        logic [7:0] d;
        int lat;
        int sel;
        int exp_lat;
        for (int s = 0; s < 2; s++) begin
            sel     = (s == 0) ? 0 : 7;
            exp_lat = (s == 0) ? 2 : 9;
            for (int i = 0; i < 16; i++) sh[i] = 8'h00;
            for (int i = 0; i < 10; i++) begin
                if (i == 0 || $urandom_range(0, 1) == 1) begin
                    a = 16'h0100 + 16'($urandom_range(0, 15));
                    d = 8'($urandom_range(0, 255));
                    ws_set(sel, 1'b0, a, 1'b1, d);
                    step();
                    ws_set(sel, 1'b0, a, 1'b0, 8'h00);
                    step();
                    step();
                    sh[a[3:0]] = d;
                end
                a = 16'h0100 + 16'($urandom_range(0, 15));
                ws_read(sel, a, rd, lat);
                total++; if (rd !== sh[a[3:0]]) begin bad++; $display("FAIL ws%0d_data addr %h: got %h want %h", sel, a, rd, sh[a[3:0]]); end
                total++; if (lat !== exp_lat) begin bad++; $display("FAIL ws%0d_latency: got %0d want %0d", sel, lat, exp_lat); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        b1.rd_req = 1'b0; b1.wr_enable = 1'b0; b1.bus_addr = 16'h0; b1.wr_data = 8'h00;
        ws_set(0, 1'b0, 16'h0, 1'b0, 8'h00);
        ws_set(7, 1'b0, 16'h0, 1'b0, 8'h00);
        test_reset();
        test_basic_read();
        test_vector();
        test_write_then_read();
        test_drop_req();
        test_write_vector();
        test_overflow();
        test_reset_mid();
        test_wait_states();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/cpu_bus_responder.md
CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

Interface
REQ-001 Parameter WAIT_STATES, default 1, extra memory cycles (0..7) inserted before read data is sampled.
REQ-002 Parameter RESET_VECTOR, default 16'h0444, value returned for reads of 16'hFFFC (low byte) and 16'hFFFD (high byte).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 bus_addr  input  16  initiator byte address for reads and writes.
REQ-006 rd_req  input  1  initiator read request, level, held until rd_ack seen.
REQ-007 rd_ack  output  1  single-cycle read-complete pulse.
REQ-008 rd_data  output  8  read data, valid while rd_ack=1, held until next completion.
REQ-009 wr_enable  input  1  single-cycle write strobe, no acknowledge.
REQ-010 wr_data  input  8  write data, qualified by wr_enable.
REQ-011 mem_addr  output  16  backing-RAM address.
REQ-012 mem_rd  output  1  backing-RAM read strobe, one cycle.
REQ-013 mem_wr  output  1  backing-RAM write strobe, one cycle.
REQ-014 mem_wdata  output  8  backing-RAM write data.
REQ-015 mem_rdata  input  8  backing-RAM read data, valid from the cycle after the mem_rd cycle, stable until the next mem access.
REQ-016 wr_overflow  output  1  sticky flag: write dropped because the write buffer was full.

Function
REQ-017 Read FSM states: IDLE, MEM_WAIT, ACK; all outputs registered.
REQ-018 IDLE, rd_req=1 sampled at edge E0, write buffer empty, bus_addr not FFFC/FFFD -> latch address, mem_rd=1 and mem_addr=address for exactly the cycle after E0, enter MEM_WAIT.
REQ-019 MEM_WAIT: counter loaded with WAIT_STATES; at edge E0+2+WAIT_STATES rd_data<=mem_rdata, rd_ack<=1, enter ACK.
REQ-020 IDLE, rd_req=1 at E0, bus_addr=FFFC/FFFD -> no mem_rd; at E0 rd_data<=vector byte, rd_ack<=1, enter ACK (latency 1 edge).
REQ-021 ACK lasts exactly one cycle; rd_ack=0 and IDLE at next edge; rd_req is ignored at that edge (old request still visible), so no double acknowledge.
REQ-022 Back-to-back reads (rd_req held high, bus_addr changed at the edge after rd_ack) -> new read accepted at first IDLE sample, using the new address.
REQ-023 rd_req dropped mid-transaction -> transaction completes, rd_ack still pulses; no abort.
REQ-024 One-entry write buffer (addr, data, valid); wr_enable=1 at any edge, any FSM state -> capture bus_addr/wr_data if buffer empty or draining at that same edge.
REQ-025 wr_enable=1 with buffer valid and not draining -> write dropped, buffer unchanged, wr_overflow<=1 until reset.
REQ-026 Drain: in IDLE with buffer valid -> mem_wr=1, mem_addr/mem_wdata=buffer for one cycle, buffer cleared; drain has priority over accepting a pending read, which starts at the next IDLE sample.
REQ-027 Pending read to the same address as the buffered write therefore returns the written data.
REQ-028 Writes to FFFC/FFFD go to RAM; the vector overlay is read-only and unaffected.
REQ-029 mem_rd and mem_wr are never high in the same cycle; at most one mem strobe per cycle.
REQ-030 Counter and address arithmetic 16-bit, no wrap logic needed; WAIT_STATES=0 gives data capture at E0+2.

Reset
REQ-031 reset_n=0 at an edge -> IDLE, rd_ack=0, rd_data=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, buffer empty, wr_overflow=0, counter=0.
REQ-032 Reset mid-read or with a buffered write -> transaction and write discarded, no rd_ack, no mem_wr after reset release.
REQ-033 First rd_req after release accepted at the first edge with reset_n=1.

Verification
REQ-034 WAIT_STATES=1, RAM[0x0450]=0xA9, rd_req at E0 addr 0x0450 -> mem_rd one cycle, rd_ack at E0+3 with rd_data=0xA9, single pulse.
REQ-035 Word read FFFC then FFFD, rd_req held high -> rd_data 0x44 then 0x04, two single rd_ack pulses, mem_rd never asserted.
REQ-036 wr_enable addr 0x2000 data 0x5A, rd_req addr 0x2000 same edge -> mem_wr first, then mem_rd, rd_data=0x5A.
REQ-037 Three wr_enable pulses on consecutive edges during a read in MEM_WAIT -> first buffered, second and third dropped, wr_overflow=1 sticky, one mem_wr after ACK.
REQ-038 reset_n=0 one cycle during MEM_WAIT -> no rd_ack, all outputs zero, next read completes normally.
REQ-039 WAIT_STATES=0 and 7, randomized reads/writes against a RAM model -> rd_data matches, rd_ack latency 2 and 9 edges respectively.
